// File: rtl/wb_result_checker.sv
// wb_result_checker: checks the register write-back stream against a loadable table of expected results
module wb_result_checker #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_idx,
    input  logic [ADDR_W-1:0]        exp_addr,
    input  logic [DATA_W-1:0]        exp_data,
    input  logic [CNT_W-1:0]         num_checks,
    input  logic                     start,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [CNT_W-1:0]         pass_count,
    output logic [CNT_W-1:0]         total_count,
    output logic                     first_fail_valid,
    output logic [$clog2(DEPTH)-1:0] first_fail_idx,
    output logic [DATA_W-1:0]        first_fail_data
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, next;
    logic [ADDR_W-1:0] tab_addr [DEPTH];
    logic [DATA_W-1:0] tab_data [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  limit;
    logic [IDLE_W-1:0] idle_cnt;
    logic [CNT_W-1:0]  cap;
    logic              hit;
    logic              last_chk;
    logic              idle_end;
    logic              launch;

    // Requests above the table size are clamped so the index never runs past the table.
    assign cap      = (num_checks > DEPTH_C) ? DEPTH_C : num_checks;
    assign hit      = (tab_addr[idx] == wb_addr) && (tab_data[idx] == wb_data);
    assign last_chk = (total_count + CNT_W'(1)) == limit;
    assign idle_end = idle_cnt == IDLE_W'(TIMEOUT - 1);
    assign launch   = (state != RUN) && start;

    // Expected table: no reset so contents survive a reset for reruns; frozen while a run is in progress.
    always_ff @(posedge clk) begin
        if (exp_we && state != RUN) begin
            tab_addr[exp_idx] <= exp_addr;
            tab_data[exp_idx] <= exp_data;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // Next state: a check on the final entry or an expired idle window both finish the run.
    always_comb begin
        next = state;
        if (state == RUN) begin
            if (wb_valid && last_chk)        next = DONE;
            else if (!wb_valid && idle_end)  next = DONE;
        end else if (start) begin
            next = (cap == '0) ? DONE : RUN;
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end

    // Result datapath: counters, idle window and first-mismatch capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx              <= '0;
            limit            <= '0;
            idle_cnt         <= '0;
            timeout          <= 1'b0;
            pass_count       <= '0;
            total_count      <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_data  <= '0;
        end else if (launch) begin
            idx              <= '0;
            limit            <= cap;
            idle_cnt         <= '0;
            timeout          <= 1'b0;
            pass_count       <= '0;
            total_count      <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_data  <= '0;
        end else if (state == RUN) begin
            if (wb_valid) begin
                total_count <= total_count + CNT_W'(1);
                pass_count  <= hit ? pass_count + CNT_W'(1) : pass_count;
                if (!hit && !first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= idx;
                    first_fail_data  <= wb_data;
                end
                idx      <= idx + IDX_W'(1);
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
                if (idle_end) timeout <= 1'b1;
            end
        end
    end
endmodule
